game_flow_ctrl: RTL and testbench

- Top-level game sequencer for the Flappy Bird design. Sits between the raw board inputs (flap button, pause switch), the game-physics engine and the display blocks.
- Sequences the engine through start/run/pause/game-over. Gates the engine's game tick. Keeps the current and high scores in BCD for the 7-segment controller. Exports the game state to the VGA renderer.

---
 rtl/game_flow_ctrl.sv | 176 +++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// Flappy Bird game sequencer: IDLE/RUN/PAUSE/OVER FSM, engine tick gating, BCD score and high score.
// Latency flap_btn->flap_pulse SYNC_STAGES+2, collide->OVER 1 cycle; no backpressure. Option AUTO_RESTART_EN: OVER exits on hold expiry.
module game_flow_ctrl #(
   parameter int SYNC_STAGES = 2,
   parameter int OVER_HOLD   = 100,
   parameter int HOLD_W      = 8
) (
   input  logic        clk,
   input  logic        clr_n,
   input  logic        tick,
   input  logic        flap_btn,
   input  logic        pause_sw,
   input  logic        collide,
   input  logic        pass,
   output logic        eng_rst,
   output logic        eng_tick,
   output logic        flap_pulse,
   output logic [1:0]  game_state,
   output logic [15:0] score_bcd,
   output logic [15:0] high_bcd,
   output logic        new_high
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_OVER  = 2'b11
   } state_t;

   localparam logic [15:0] SCORE_MAX = 16'h9999;

   state_t              state;
   state_t              state_nxt;
   logic [SYNC_STAGES-1:0] flap_sync;
   logic [SYNC_STAGES-1:0] pause_sync;
   logic                flap_s;
   logic                flap_d;
   logic                flap_edge;
   logic                pause_s;
   logic [HOLD_W-1:0]   hold_cnt;
   logic                hold_zero;
   logic                start_game;
   logic                enter_over;
   logic                pulse_nxt;
   logic [15:0]         score_nxt;

   // Ripple a +1 through four BCD digits; the caller handles saturation at 9999.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         flap_sync  <= '0;
         pause_sync <= '0;
         flap_d     <= 1'b0;
         flap_edge  <= 1'b0;
      end else begin
         flap_sync  <= {flap_sync[SYNC_STAGES-2:0], flap_btn};
         pause_sync <= {pause_sync[SYNC_STAGES-2:0], pause_sw};
         flap_d     <= flap_s;
         // Registered edge: a held button yields exactly one strobe.
         flap_edge  <= flap_s & ~flap_d;
      end
   end

   assign flap_s     = flap_sync[SYNC_STAGES-1];
   assign pause_s    = pause_sync[SYNC_STAGES-1];
   assign hold_zero  = (hold_cnt == '0);
   assign game_state = state;

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (flap_edge) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            // A qualifying collision outranks a pause request.
            if (tick && collide) state_nxt = ST_OVER;
            else if (pause_s)    state_nxt = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (!pause_s) state_nxt = ST_RUN;
         end
         ST_OVER: begin
`ifdef AUTO_RESTART_EN
            if (hold_zero) state_nxt = ST_IDLE;
`else
            if (hold_zero && flap_edge) state_nxt = ST_IDLE;
`endif
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      eng_tick   = 1'b0;
      start_game = 1'b0;
      enter_over = 1'b0;
      pulse_nxt  = 1'b0;
      case (state)
         ST_IDLE: begin
            start_game = flap_edge;
            pulse_nxt  = flap_edge;
         end
         ST_RUN: begin
            eng_tick   = tick;
            enter_over = (state_nxt == ST_OVER);
            pulse_nxt  = flap_edge && (state_nxt == ST_RUN);
         end
         default: ;
      endcase
   end

   always_comb begin
      score_nxt = score_bcd;
      if (state == ST_RUN && pass && score_bcd != SCORE_MAX) begin
         score_nxt = bcd_inc(score_bcd);
      end
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         eng_rst    <= 1'b1;
         flap_pulse <= 1'b0;
         score_bcd  <= '0;
         high_bcd   <= '0;
         new_high   <= 1'b0;
         hold_cnt   <= '0;
      end else begin
         eng_rst    <= (state_nxt == ST_IDLE);
         flap_pulse <= pulse_nxt;
         if (start_game) begin
            score_bcd <= '0;
            new_high  <= 1'b0;
         end else begin
            score_bcd <= score_nxt;
         end
         if (enter_over) begin
            hold_cnt <= HOLD_W'(OVER_HOLD);
            // Packed BCD orders like binary, so a plain compare is MSD-first digit-wise.
            if (score_nxt > high_bcd) begin
               high_bcd <= score_nxt;
               new_high <= 1'b1;
            end
         end else if (state == ST_OVER && tick && !hold_zero) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Randomized bench for game_flow_ctrl: an integer-level game model feeds a queue, a negedge monitor compares.
module tb_game_flow_ctrl;
   localparam int S    = 2;
   localparam int HOLD = 100;
   localparam int IDLE = 0, RUN = 1, PAUSE = 2, OVER = 3;

   logic        clk = 1'b0;
   logic        clr_n = 1'b0, tick = 1'b0, flap_btn = 1'b0, pause_sw = 1'b0;
   logic        collide = 1'b0, pass = 1'b0;
   logic        eng_rst, eng_tick, flap_pulse, new_high;
   logic [1:0]  game_state;
   logic [15:0] score_bcd, high_bcd;

   always #5 clk = ~clk;

   game_flow_ctrl #(.SYNC_STAGES(S), .OVER_HOLD(HOLD), .HOLD_W(8)) dut (
      .clk(clk), .clr_n(clr_n), .tick(tick), .flap_btn(flap_btn), .pause_sw(pause_sw),
      .collide(collide), .pass(pass), .eng_rst(eng_rst), .eng_tick(eng_tick),
      .flap_pulse(flap_pulse), .game_state(game_state), .score_bcd(score_bcd),
      .high_bcd(high_bcd), .new_high(new_high)
   );

   typedef struct {
      int          cyc;
      logic [1:0]  st;
      logic        rst, etk, fp, nh;
      logic [15:0] sc, hi;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0, errors = 0, cyc_n = 0;

   // Reference model: decimal integers and sample-history queues.
   int  m_state = IDLE, m_score = 0, m_high = 0, m_hold = 0;
   bit  m_nh = 0, m_rst = 1, m_pulse = 0, m_fprev = 0, m_edge = 0;
   bit  fq[$], pq[$];

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic bit rnd(input int n);
      return ($urandom_range(n - 1) == 0);
   endfunction

   function automatic void clear_sync();
      fq.delete(); pq.delete();
      for (int i = 0; i < S; i++) begin fq.push_back(1'b0); pq.push_back(1'b0); end
      m_fprev = 0; m_edge = 0;
   endfunction

   function automatic void model_step(input bit b, input bit p, input bit t, input bit c,
                                      input bit s, input bit r);
      bit fs, ps_lvl, edge_now, npulse;
      int nst, h;
      if (!r) begin
         m_state = IDLE; m_score = 0; m_high = 0; m_hold = 0;
         m_nh = 0; m_rst = 1; m_pulse = 0;
         clear_sync();
         return;
      end
      fs = fq[S-1]; ps_lvl = pq[S-1]; edge_now = m_edge;
      m_edge = fs & ~m_fprev; m_fprev = fs;
      fq.push_front(b); void'(fq.pop_back());
      pq.push_front(p); void'(pq.pop_back());
      nst = m_state; npulse = 0; h = m_hold;
      case (m_state)
         IDLE: if (edge_now) begin nst = RUN; m_score = 0; m_nh = 0; npulse = 1; end
         RUN: begin
            if (s) m_score = (m_score < 9999) ? m_score + 1 : 9999;
            if (t && c) begin
               nst = OVER; m_hold = HOLD;
               if (m_score > m_high) begin m_high = m_score; m_nh = 1; end
            end else if (ps_lvl) nst = PAUSE;
            else npulse = edge_now;
         end
         PAUSE: if (!ps_lvl) nst = RUN;
         default: begin
            if (t && h > 0) m_hold = h - 1;
`ifdef AUTO_RESTART_EN
            if (h == 0) nst = IDLE;
`else
            if (h == 0 && edge_now) nst = IDLE;
`endif
         end
      endcase
      m_state = nst; m_pulse = npulse; m_rst = (nst == IDLE);
   endfunction

   task automatic chk(input string name, input int cyc, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("game_state", mon_e.cyc, 16'(game_state), 16'(mon_e.st));
         chk("eng_rst",    mon_e.cyc, 16'(eng_rst),    16'(mon_e.rst));
         chk("eng_tick",   mon_e.cyc, 16'(eng_tick),   16'(mon_e.etk));
         chk("flap_pulse", mon_e.cyc, 16'(flap_pulse), 16'(mon_e.fp));
         chk("score_bcd",  mon_e.cyc, score_bcd,       mon_e.sc);
         chk("high_bcd",   mon_e.cyc, high_bcd,        mon_e.hi);
         chk("new_high",   mon_e.cyc, 16'(new_high),   16'(mon_e.nh));
      end
   end

   // One clock of stimulus: drive, queue the model's view of this cycle, advance the model.
   task automatic cyc(input bit b, input bit p, input bit t, input bit c, input bit s, input bit r);
      exp_t e;
      flap_btn = b; pause_sw = p; tick = t; collide = c; pass = s; clr_n = r;
      e.cyc = cyc_n; e.st = 2'(m_state); e.rst = m_rst; e.etk = t && (m_state == RUN);
      e.fp = m_pulse; e.sc = to_bcd(m_score); e.hi = to_bcd(m_high); e.nh = m_nh;
      exp_q.push_back(e);
      model_step(b, p, t, c, s, r);
      cyc_n++;
      @(posedge clk); #1;
   endtask

   task automatic start_game();
      repeat (S + 2) cyc(0, 0, rnd(2), 0, 0, 1);
      repeat (S + 3) cyc(1, 0, rnd(2), 0, 0, 1);
      repeat (2) cyc(0, 0, rnd(2), 0, 0, 1);
   endtask

   task automatic passes(input int n);
      repeat (n) begin
         cyc(0, 0, rnd(2), 0, 1, 1);
         cyc(0, 0, rnd(2), 0, 0, 1);
      end
   endtask

   task automatic leave_over();
      int guard = 0;
      // A press around hold=50 must be ignored.
      while (m_state == OVER && m_hold > 0 && guard < 3000) begin
         cyc(m_hold <= 50 && m_hold > 45, 0, rnd(2), 0, 0, 1);
         guard++;
      end
`ifdef AUTO_RESTART_EN
      repeat (3) cyc(0, 0, rnd(2), 0, 0, 1);
`else
      repeat (S + 3) cyc(0, 0, rnd(2), 0, 0, 1);
      repeat (S + 4) cyc(1, 0, rnd(2), 0, 0, 1);
`endif
   endtask

   task automatic pause_test();
      repeat (S + 3) cyc(0, 1, rnd(2), 0, 0, 1);
      repeat (S + 3) cyc(1, 1, rnd(2), 0, rnd(2), 1);
      repeat (S + 3) cyc(0, 1, rnd(2), 0, 0, 1);
      repeat (S + 3) cyc(0, 0, rnd(2), 0, 0, 1);
      // Button one cycle ahead of the switch lines flap_edge up with the RUN->PAUSE transition.
      cyc(1, 0, rnd(2), 0, 0, 1);
      repeat (S + 3) cyc(1, 1, rnd(2), 0, 0, 1);
      repeat (S + 3) cyc(0, 0, rnd(2), 0, 0, 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit rb = 0, rp = 0;
      clear_sync();
      @(posedge clk); #1;
      repeat (3) cyc(0, 0, 0, 0, 0, 0);
      repeat (2) cyc(0, 0, 0, 0, 0, 1);

      start_game();
      passes(12);
      repeat (5) cyc(0, 0, rnd(2), 0, 0, 1);
      repeat (2) cyc(0, 0, 1, 0, 0, 0);
      repeat (2) cyc(0, 0, 0, 0, 0, 1);

      start_game(); passes(4); cyc(0, 0, 1, 1, 0, 1); leave_over();
      start_game(); passes(4); cyc(0, 0, 1, 1, 1, 1); leave_over();
      start_game(); passes(2); cyc(0, 0, 1, 1, 0, 1); leave_over();
      start_game(); pause_test(); passes(5); cyc(0, 1, 1, 1, 0, 1); leave_over();

      for (int i = 0; i < 4000; i++) begin
         if (rnd(8))  rb = ~rb;
         if (rnd(40)) rp = ~rp;
         cyc(rb, rp, rnd(3), rnd(15), rnd(4), !rnd(400));
      end

      repeat (2) cyc(0, 0, 0, 0, 0, 0);
      start_game();
      repeat (10005) cyc(0, 0, 0, 0, 1, 1);
      cyc(0, 0, 1, 1, 1, 1);
      repeat (20) cyc(0, 0, rnd(2), 0, 0, 1);
      repeat (2) cyc(0, 0, 1, 0, 0, 0);
      repeat (3) cyc(0, 0, 0, 0, 0, 1);

      repeat (2) @(negedge clk);
      chk("drain", cyc_n, 16'(exp_q.size()), 16'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
